mem_port_responder: RTL

MEM_PORT_RESPONDER -- requirements
Module: mem_port_responder

---
 rtl/mem_port_responder_pkg.sv | 24 ++
 rtl/mem_port_responder_ram.sv | 27 ++
 rtl/mem_port_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_responder_pkg.sv
// Shared memory-unit definitions: request codes and error codes.
// The NIL address is always the all-ones address of the configured width,
// so it is derived inside each user from its own ADDR_W.
package mem_port_responder_pkg;

    typedef enum logic [1:0] {
        FUNC_NOP          = 2'b00,
        FUNC_GET_CONTENTS = 2'b01,
        FUNC_SET_CONTENTS = 2'b10,
        FUNC_ALLOC        = 2'b11
    } mem_func_e;

    localparam logic [7:0] ERR_NONE       = 8'h00;
    localparam logic [7:0] ERR_BUSY       = 8'h01;
    localparam logic [7:0] ERR_NIL_ACCESS = 8'h02;
    localparam logic [7:0] ERR_POOL_EMPTY = 8'h03;

    // The first nonzero error code sticks; later codes are discarded.
    function automatic logic [7:0] sticky_error(input logic [7:0] current,
                                                input logic [7:0] raised);
        return (current != ERR_NONE) ? current : raised;
    endfunction

endpackage

// File: rtl/mem_port_responder_ram.sv
// Single-port synchronous RAM, read-first, one-cycle registered read.
// Contents are deliberately not reset so a reset never wipes stored words.
module mem_sp_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Port access: optional write plus registered read of the old word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/mem_port_responder.sv
// Memory-unit responder: accepts one-cycle request strobes from the
// traversal/execute initiators, runs GET/SET/ALLOC/NOP against a single-port
// RAM and reports completion with a one-cycle mem_ready pulse.
module mem_port_responder
    import mem_port_responder_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 64,
    parameter logic [ADDR_W-1:0] FREE_BASE = ADDR_W'(512)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_execute,
    input  logic [1:0]        mem_func,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    input  logic [DATA_W-1:0] write_data,
    output logic              mem_ready,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [ADDR_W-1:0] free_addr,
    output logic [7:0]        error
);

    localparam logic [ADDR_W-1:0] NIL_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD1,
        S_RD2,
        S_WR,
        S_ALLOC,
        S_DONE
    } state_e;

    state_e            state_q;
    mem_func_e         func_q;
    logic [ADDR_W-1:0] addr1_q;
    logic [ADDR_W-1:0] addr2_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word1_q;
    logic [DATA_W-1:0] read_data1_q;
    logic [DATA_W-1:0] read_data2_q;
    logic [ADDR_W-1:0] free_addr_q;
    logic [7:0]        error_q;
    logic [7:0]        error_d;
    logic              mem_ready_q;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    logic              addr1_nil;
    logic              addr2_nil;
    logic              nil_access;
    logic [7:0]        err_raised;

    assign addr1_nil = (addr1_q == NIL_ADDR);
    assign addr2_nil = (addr2_q == NIL_ADDR);

    // A GET touching NIL on either side, or a SET aimed at NIL, is a NIL access.
    assign nil_access = ((func_q == FUNC_GET_CONTENTS) && (addr1_nil || addr2_nil)) ||
                        ((func_q == FUNC_SET_CONTENTS) && addr1_nil);

    // RAM port steering. The address1 read is launched on the sampling edge
    // straight from the inputs, so word1 is on rdata during RD1 and word2
    // during RD2. Writes to NIL are suppressed at the port.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = addr1_q;
        case (state_q)
            S_IDLE: begin
                ram_en   = mem_execute && (mem_func == FUNC_GET_CONTENTS);
                ram_addr = address1;
            end
            S_RD1: begin
                ram_en   = 1'b1;
                ram_addr = addr2_q;
            end
            S_WR: begin
                ram_en   = !addr1_nil;
                ram_we   = !addr1_nil;
                ram_addr = addr1_q;
            end
            default: ;
        endcase
    end

    // Error detection: a strobe outside IDLE wins over a functional error
    // raised on the same edge; the first nonzero code is then held.
    always_comb begin
        err_raised = ERR_NONE;
        if (mem_execute && (state_q != S_IDLE)) begin
            err_raised = ERR_BUSY;
        end else begin
            case (state_q)
                S_RD1, S_WR: if (nil_access) err_raised = ERR_NIL_ACCESS;
                S_ALLOC:     if (free_addr_q == NIL_ADDR) err_raised = ERR_POOL_EMPTY;
                default: ;
            endcase
        end
        error_d = sticky_error(error_q, err_raised);
    end

    mem_sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Request FSM with registered outputs; mem_ready is set on the edge
    // that enters DONE so it is high for exactly the DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            func_q       <= FUNC_NOP;
            addr1_q      <= '0;
            addr2_q      <= '0;
            wdata_q      <= '0;
            word1_q      <= '0;
            read_data1_q <= '0;
            read_data2_q <= '0;
            free_addr_q  <= FREE_BASE;
            error_q      <= ERR_NONE;
            mem_ready_q  <= 1'b0;
        end else begin
            mem_ready_q <= 1'b0;
            error_q     <= error_d;
            case (state_q)
                S_IDLE: begin
                    if (mem_execute) begin
                        func_q  <= mem_func_e'(mem_func);
                        addr1_q <= address1;
                        addr2_q <= address2;
                        wdata_q <= write_data;
                        case (mem_func_e'(mem_func))
                            FUNC_GET_CONTENTS: state_q <= S_RD1;
                            FUNC_SET_CONTENTS: state_q <= S_WR;
                            FUNC_ALLOC:        state_q <= S_ALLOC;
                            default: begin
                                state_q     <= S_DONE;
                                mem_ready_q <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RD1: begin
                    word1_q <= addr1_nil ? '0 : ram_rdata;
                    state_q <= S_RD2;
                end
                S_RD2: begin
                    read_data1_q <= word1_q;
                    read_data2_q <= addr2_nil ? '0 : ram_rdata;
                    state_q      <= S_DONE;
                    mem_ready_q  <= 1'b1;
                end
                S_WR: begin
                    state_q     <= S_DONE;
                    mem_ready_q <= 1'b1;
                end
                S_ALLOC: begin
                    // When exhausted, free_addr already equals NIL, so the
                    // returned word is NIL and the pointer stays put.
                    read_data1_q <= DATA_W'(free_addr_q);
                    if (free_addr_q != NIL_ADDR) begin
                        free_addr_q <= free_addr_q + 1'b1;
                    end
                    state_q     <= S_DONE;
                    mem_ready_q <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_ready  = mem_ready_q;
    assign read_data1 = read_data1_q;
    assign read_data2 = read_data2_q;
    assign free_addr  = free_addr_q;
    assign error      = error_q;

endmodule
